// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID decode, load-use hazard detection, beq/j redirect,
// ID/EX -> EX/MEM -> MEM/WB control/destination tracking and EX forwarding selects.
module pipe_control_unit #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned OP_W   = 6,
   parameter int unsigned CTRL_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [OP_W-1:0]   Op_i,
   input  logic [REG_AW-1:0] Rs_i,
   input  logic [REG_AW-1:0] Rt_i,
   input  logic [REG_AW-1:0] Rd_i,
   input  logic              Eq_i,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic [1:0]        mem_ctrl_o,
   output logic [1:0]        wb_ctrl_o,
   output logic [REG_AW-1:0] mem_dest_o,
   output logic [REG_AW-1:0] wb_dest_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              stall_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              flush_o,
   output logic              Branch_o,
   output logic              Jump_o,
   output logic              illegal_o
);
   localparam int unsigned DEC_W = 8;
   localparam int unsigned B_REGWRITE = 0;
   localparam int unsigned B_MEMREAD  = 2;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   logic [DEC_W-1:0]  dec_ctrl;
   logic [REG_AW-1:0] dec_dest;
   logic              uses_rt;
   logic              is_beq;
   logic              is_j;
   logic              legal;
   logic              stall;
   logic              bubble;

   logic [DEC_W-1:0]  idex_ctrl;
   logic [REG_AW-1:0] idex_dest;
   logic [REG_AW-1:0] idex_rs;
   logic [REG_AW-1:0] idex_rt;
   logic [1:0]        exmem_mem;
   logic [1:0]        exmem_wb;
   logic [REG_AW-1:0] exmem_dest;
   logic [1:0]        memwb_wb;
   logic [REG_AW-1:0] memwb_dest;

   // Opcode decode: {RegDst, ALUSrc, ALUOp[1:0], MemWrite, MemRead, MemtoReg, RegWrite}
   always_comb begin
      dec_ctrl = '0;
      dec_dest = '0;
      uses_rt  = 1'b0;
      is_beq   = 1'b0;
      is_j     = 1'b0;
      legal    = 1'b1;
      case (Op_i)
         OP_RTYPE: begin dec_ctrl = 8'b1000_0001; dec_dest = Rd_i; uses_rt = 1'b1; end
         OP_ADDI:  begin dec_ctrl = 8'b0101_0001; dec_dest = Rt_i; end
         OP_ORI:   begin dec_ctrl = 8'b0110_0001; dec_dest = Rt_i; end
         OP_LW:    begin dec_ctrl = 8'b0101_0111; dec_dest = Rt_i; end
         OP_SW:    begin dec_ctrl = 8'b0101_1000; uses_rt = 1'b1; end
         OP_BEQ:   begin dec_ctrl = 8'b0011_0000; uses_rt = 1'b1; is_beq = 1'b1; end
         OP_J:     is_j = 1'b1;
         default:  legal = 1'b0;
      endcase
      if (!dec_ctrl[B_REGWRITE]) dec_dest = '0;
   end

   // Load in EX whose destination is read in ID; $0 never hazards
   assign stall = valid_i & idex_ctrl[B_MEMREAD] & (idex_dest != '0) &
                  ((idex_dest == Rs_i) | (uses_rt & (idex_dest == Rt_i)));
   assign bubble = ~valid_i | stall | ~legal;

   assign stall_o      = stall;
   assign pc_write_o   = ~stall;
   assign ifid_write_o = ~stall;
   assign illegal_o    = valid_i & ~legal;
   assign Branch_o     = valid_i & is_beq & Eq_i & ~stall;
   assign Jump_o       = valid_i & is_j & ~stall;
   assign flush_o      = Branch_o | Jump_o;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idex_ctrl  <= '0;
         idex_dest  <= '0;
         idex_rs    <= '0;
         idex_rt    <= '0;
         exmem_mem  <= '0;
         exmem_wb   <= '0;
         exmem_dest <= '0;
         memwb_wb   <= '0;
         memwb_dest <= '0;
      end else begin
         if (bubble) begin
            idex_ctrl <= '0;
            idex_dest <= '0;
            idex_rs   <= '0;
            idex_rt   <= '0;
         end else begin
            idex_ctrl <= dec_ctrl;
            idex_dest <= dec_dest;
            idex_rs   <= Rs_i;
            idex_rt   <= Rt_i;
         end
         exmem_mem  <= idex_ctrl[3:2];
         exmem_wb   <= idex_ctrl[1:0];
         exmem_dest <= idex_dest;
         memwb_wb   <= exmem_wb;
         memwb_dest <= exmem_dest;
      end
   end

   // EX/MEM result is younger, so it wins over MEM/WB
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      if (exmem_wb[0] && (exmem_dest != '0) && (exmem_dest == src)) return 2'b10;
      if (memwb_wb[0] && (memwb_dest != '0) && (memwb_dest == src)) return 2'b01;
      return 2'b00;
   endfunction

   assign fwd_a_o    = fwd_sel(idex_rs);
   assign fwd_b_o    = fwd_sel(idex_rt);
   assign ex_ctrl_o  = CTRL_W'(idex_ctrl);
   assign mem_ctrl_o = exmem_mem;
   assign wb_ctrl_o  = memwb_wb;
   assign mem_dest_o = exmem_dest;
   assign wb_dest_o  = memwb_dest;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed scenarios plus random
// instruction streams compared every cycle against a record-history model.
module tb_pipe_control_unit;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic [5:0]  Op_i = '0;
   logic [4:0]  Rs_i = '0, Rt_i = '0, Rd_i = '0;
   logic        Eq_i = 1'b0;
   logic [31:0] ex_ctrl_o;
   logic [1:0]  mem_ctrl_o, wb_ctrl_o, fwd_a_o, fwd_b_o;
   logic [4:0]  mem_dest_o, wb_dest_o;
   logic        stall_o, pc_write_o, ifid_write_o, flush_o, Branch_o, Jump_o, illegal_o;

   pipe_control_unit #(.REG_AW(5), .OP_W(6), .CTRL_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
      .Rs_i(Rs_i), .Rt_i(Rt_i), .Rd_i(Rd_i), .Eq_i(Eq_i),
      .ex_ctrl_o(ex_ctrl_o), .mem_ctrl_o(mem_ctrl_o), .wb_ctrl_o(wb_ctrl_o),
      .mem_dest_o(mem_dest_o), .wb_dest_o(wb_dest_o),
      .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o),
      .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .flush_o(flush_o),
      .Branch_o(Branch_o), .Jump_o(Jump_o), .illegal_o(illegal_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [5:0] R = 6'h00, ADDI = 6'h08, ORI = 6'h0d, LW = 6'h23,
                          SW = 6'h2b, BEQ = 6'h04, J = 6'h02;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // One issued instruction as it travels down the pipe
   typedef struct packed {
      logic [7:0] ctrl;
      logic [4:0] dest;
      logic [4:0] rs;
      logic [4:0] rt;
   } rec_t;

   // hist[k]: record that entered ID/EX k edges ago (1 = EX, 2 = MEM, 3 = WB)
   rec_t hist [1:3] = '{default: '0};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Decode table straight from the opcode list
   function automatic void decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                                  output logic [7:0] ctrl, output logic [4:0] dst,
                                  output logic urt, output logic legal,
                                  output logic br, output logic jp);
      ctrl = 8'h00; dst = 5'd0; urt = 1'b0; legal = 1'b1; br = 1'b0; jp = 1'b0;
      if      (op == R)    begin ctrl = 8'b1000_0001; dst = rd; urt = 1'b1; end
      else if (op == ADDI) begin ctrl = 8'b0101_0001; dst = rt; end
      else if (op == ORI)  begin ctrl = 8'b0110_0001; dst = rt; end
      else if (op == LW)   begin ctrl = 8'b0101_0111; dst = rt; end
      else if (op == SW)   begin ctrl = 8'b0101_1000; urt = 1'b1; end
      else if (op == BEQ)  begin ctrl = 8'b0011_0000; urt = 1'b1; br = 1'b1; end
      else if (op == J)    jp = 1'b1;
      else                 legal = 1'b0;
   endfunction

   function automatic logic m_stall();
      logic [7:0] c; logic [4:0] d; logic u, l, b, j;
      decode(Op_i, Rt_i, Rd_i, c, d, u, l, b, j);
      return valid_i && hist[1].ctrl[2] && hist[1].dest != 5'd0 &&
             (hist[1].dest == Rs_i || (u && hist[1].dest == Rt_i));
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] src);
      if (hist[2].ctrl[0] && hist[2].dest != 5'd0 && hist[2].dest == src) return 2'b10;
      if (hist[3].ctrl[0] && hist[3].dest != 5'd0 && hist[3].dest == src) return 2'b01;
      return 2'b00;
   endfunction

   // Model advance: what enters ID/EX is the decoded instruction unless it is a bubble
   always @(posedge clk_i or negedge rst_i) begin
      logic [7:0] c; logic [4:0] d; logic u, l, b, j;
      rec_t nxt;
      if (!rst_i) begin
         for (int k = 1; k <= 3; k++) hist[k] = '0;
      end else begin
         decode(Op_i, Rt_i, Rd_i, c, d, u, l, b, j);
         nxt = '0;
         if (valid_i && l && !m_stall()) nxt = '{ctrl: c, dest: c[0] ? d : 5'd0, rs: Rs_i, rt: Rt_i};
         hist[3] = hist[2];
         hist[2] = hist[1];
         hist[1] = nxt;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk_i) begin
      logic [7:0] c; logic [4:0] d; logic u, l, b, j, st, eb, ej;
      if (check_en) begin
         decode(Op_i, Rt_i, Rd_i, c, d, u, l, b, j);
         st = m_stall();
         eb = valid_i && b && Eq_i && !st;
         ej = valid_i && j && !st;
         chk("ex_ctrl",  ex_ctrl_o, {24'd0, hist[1].ctrl});
         chk("mem_ctrl", 32'(mem_ctrl_o), 32'(hist[2].ctrl[3:2]));
         chk("wb_ctrl",  32'(wb_ctrl_o),  32'(hist[3].ctrl[1:0]));
         chk("mem_dest", 32'(mem_dest_o), 32'(hist[2].dest));
         chk("wb_dest",  32'(wb_dest_o),  32'(hist[3].dest));
         chk("fwd_a",    32'(fwd_a_o), 32'(m_fwd(hist[1].rs)));
         chk("fwd_b",    32'(fwd_b_o), 32'(m_fwd(hist[1].rt)));
         chk("stall",    32'(stall_o), 32'(st));
         chk("pc_write", 32'(pc_write_o), 32'(!st));
         chk("ifid_write", 32'(ifid_write_o), 32'(!st));
         chk("branch",   32'(Branch_o), 32'(eb));
         chk("jump",     32'(Jump_o), 32'(ej));
         chk("flush",    32'(flush_o), 32'(eb || ej));
         chk("illegal",  32'(illegal_o), 32'(valid_i && !l));
      end
   end

   task automatic drv(input logic v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic eq);
      valid_i = v; Op_i = op; Rs_i = rs; Rt_i = rt; Rd_i = rd; Eq_i = eq;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drv_rand();
      logic [5:0] ops [7];
      logic [5:0] op;
      ops = '{R, ADDI, ORI, LW, SW, BEQ, J};
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      drv(1'($urandom_range(0, 9) != 0), op, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
   endtask

   initial begin
      #1 rst_i = 1'b0;
      check_en = 1'b1;
      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin drv_rand(); step(); end
      chk("rst ex_ctrl",  ex_ctrl_o, 32'd0);
      chk("rst mem_ctrl", 32'(mem_ctrl_o), 32'd0);
      chk("rst wb_ctrl",  32'(wb_ctrl_o), 32'd0);
      chk("rst pc_write", 32'(pc_write_o), 32'd1);
      chk("rst stall",    32'(stall_o), 32'd0);
      rst_i = 1'b1;

      // R-type writing $3 flows to WB
      drv(1'b1, R, 5'd1, 5'd2, 5'd3, 1'b0); step();
      chk("rtype ex_ctrl", ex_ctrl_o, 32'h81);
      drv(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0); step(); step();
      chk("rtype wb_ctrl", 32'(wb_ctrl_o), 32'd1);
      chk("rtype wb_dest", 32'(wb_dest_o), 32'd3);

      // lw $2 then add $4,$2,$5: one stall, then MEM/WB forward
      drv(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0); step();
      drv(1'b1, R, 5'd2, 5'd5, 5'd4, 1'b0); #1;
      chk("lu stall", 32'(stall_o), 32'd1);
      chk("lu pc_write", 32'(pc_write_o), 32'd0);
      step();
      chk("lu bubble", ex_ctrl_o, 32'd0);
      chk("lu stall clear", 32'(stall_o), 32'd0);
      step();
      chk("lu issue", ex_ctrl_o, 32'h81);
      chk("lu fwd_a", 32'(fwd_a_o), 32'd1);

      // add $1 then sub $6,$1,$1: EX/MEM forward on both operands
      drv(1'b1, R, 5'd2, 5'd3, 5'd1, 1'b0); step();
      drv(1'b1, R, 5'd1, 5'd1, 5'd6, 1'b0); step();
      chk("exmem fwd_a", 32'(fwd_a_o), 32'd2);
      chk("exmem fwd_b", 32'(fwd_b_o), 32'd2);
      drv(1'b1, R, 5'd2, 5'd3, 5'd0, 1'b0); step();
      drv(1'b1, R, 5'd0, 5'd0, 5'd7, 1'b0); step();
      chk("zero fwd_a", 32'(fwd_a_o), 32'd0);
      chk("zero fwd_b", 32'(fwd_b_o), 32'd0);

      // beq taken / not taken, beq held off by a load-use stall, jump
      drv(1'b1, BEQ, 5'd3, 5'd4, 5'd0, 1'b1); #1;
      chk("beq taken", 32'(Branch_o), 32'd1);
      chk("beq flush", 32'(flush_o), 32'd1);
      Eq_i = 1'b0; #1;
      chk("beq not taken", 32'(Branch_o), 32'd0);
      drv(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0); step();
      drv(1'b1, BEQ, 5'd2, 5'd3, 5'd0, 1'b1); #1;
      chk("beq stall", 32'(stall_o), 32'd1);
      chk("beq stalled", 32'(Branch_o), 32'd0);
      step();
      chk("beq after stall", 32'(Branch_o), 32'd1);
      drv(1'b1, J, 5'd0, 5'd0, 5'd0, 1'b0); #1;
      chk("jump", 32'(Jump_o), 32'd1);
      step();

      // Illegal opcode bubbles; ori decode
      drv(1'b1, 6'h3f, 5'd1, 5'd2, 5'd3, 1'b0); #1;
      chk("illegal", 32'(illegal_o), 32'd1);
      step();
      chk("illegal bubble", ex_ctrl_o, 32'd0);
      drv(1'b1, ORI, 5'd1, 5'd5, 5'd0, 1'b0); step();
      chk("ori ex_ctrl", ex_ctrl_o, 32'h61);

      // Asynchronous reset with lw in EX/MEM
      drv(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0); step();
      drv(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0); step();
      chk("lw in mem", 32'(mem_ctrl_o), 32'd1);
      #2 rst_i = 1'b0;
      #1;
      chk("async mem_ctrl", 32'(mem_ctrl_o), 32'd0);
      chk("async wb_ctrl", 32'(wb_ctrl_o), 32'd0);
      step();
      rst_i = 1'b1;

      // Random streams; a stalled instruction is held in IF/ID as the CPU would
      for (int i = 0; i < 800; i++) begin
         if (i == 400) rst_i = 1'b0;
         if (i == 402) rst_i = 1'b1;
         if (!m_stall() || $urandom_range(0, 4) == 0) drv_rand();
         step();
      end

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
